vga_sync_monitor: RTL and testbench

- Receive-side counterpart of the VGA timing generator: consumes hs, vs, blank and pixel_clk and recovers the pixel coordinates of each active pixel.
- Measures line and frame geometry, checks it against the expected 640x480 / 800x525 timing, and reports lock and error status.
- Sits beside the timing generator in the same 50 MHz Clk domain; feeds frame capture, on-screen debug and self-check logic.

---
 rtl/vga_sync_monitor.sv | 196 +++++++++++++++++++
 tb/tb_vga_sync_monitor.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_monitor.sv
// Recovers pixel coordinates from hs/vs/blank and checks line/frame geometry against the
// expected timing; all state advances on the pixel strobe derived from pixel_clk in the Clk domain.
module vga_sync_monitor #(
  parameter int EXP_HTOTAL   = 800,
  parameter int EXP_HACTIVE  = 640,
  parameter int EXP_VTOTAL   = 525,
  parameter int EXP_VACTIVE  = 480,
  parameter int LOCK_FRAMES  = 2,
  parameter int STALL_CYCLES = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       pixel_clk,
  input  logic       hs,
  input  logic       vs,
  input  logic       blank,
  output logic       pix_valid,
  output logic [9:0] RecX,
  output logic [9:0] RecY,
  output logic       locked,
  output logic       line_err,
  output logic       frame_done,
  output logic [9:0] h_total_meas,
  output logic [9:0] h_active_meas,
  output logic [9:0] v_total_meas,
  output logic [7:0] err_count
);
  localparam logic [9:0] HTOT   = 10'(EXP_HTOTAL);
  localparam logic [9:0] HACT   = 10'(EXP_HACTIVE);
  localparam logic [9:0] VTOT   = 10'(EXP_VTOTAL);
  localparam logic [9:0] VACT   = 10'(EXP_VACTIVE);
  localparam logic [7:0] LOCK_N = 8'(LOCK_FRAMES);
  localparam int         SW     = $clog2(STALL_CYCLES + 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL_CYCLES - 1);

  typedef enum logic [1:0] {HUNT, MEASURE, LOCKED} state_t;
  state_t state;

  logic          pclk_q, pclk_d, hs_q, vs_q, blank_q;
  logic          hs_p, vs_p, blank_p;
  logic [9:0]    hcnt, acnt, lcnt, alcnt;
  logic          frame_bad;
  logic [7:0]    good_cnt;
  logic [SW-1:0] stall_cnt;

  logic       stb, hs_fall, vs_fall, blank_rise, blank_fall;
  logic       line_bad, frame_good, watchdog;
  logic [9:0] htot_now, lcnt_end;
  logic [7:0] good_next;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  assign stb        = pclk_q & ~pclk_d;
  assign hs_fall    = stb & hs_p & ~hs_q;
  assign vs_fall    = stb & vs_p & ~vs_q;
  assign blank_rise = stb & ~blank_p & blank_q;
  assign blank_fall = stb & blank_p & ~blank_q;

  assign htot_now   = sat_inc(hcnt);
  // An hs fall on the vs-fall strobe still belongs to the frame that is ending.
  assign lcnt_end   = hs_fall ? sat_inc(lcnt) : lcnt;
  assign line_bad   = (hs_fall & (htot_now != HTOT)) | (blank_fall & (acnt != HACT));
  assign frame_good = ~frame_bad & ~line_bad & (lcnt_end == VTOT) & (alcnt == VACT);
  assign watchdog   = (~stb & (stall_cnt >= STALL_LAST)) | (hcnt == 10'h3FF);
  assign good_next  = good_cnt + 8'd1;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pclk_q    <= 1'b0;
      pclk_d    <= 1'b0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      blank_q   <= 1'b0;
      hs_p      <= 1'b0;
      vs_p      <= 1'b0;
      blank_p   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      pclk_q  <= pixel_clk;
      pclk_d  <= pclk_q;
      hs_q    <= hs;
      vs_q    <= vs;
      blank_q <= blank;
      if (stb) begin
        hs_p    <= hs_q;
        vs_p    <= vs_q;
        blank_p <= blank_q;
      end
      if (stb)
        stall_cnt <= '0;
      else if (stall_cnt != '1)
        stall_cnt <= stall_cnt + SW'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hcnt          <= '0;
      acnt          <= '0;
      lcnt          <= '0;
      alcnt         <= '0;
      frame_bad     <= 1'b0;
      h_total_meas  <= '0;
      h_active_meas <= '0;
      RecX          <= '0;
      RecY          <= '0;
      line_err      <= 1'b0;
      pix_valid     <= 1'b0;
    end else begin
      line_err  <= 1'b0;
      pix_valid <= stb & blank_q & locked;
      if (stb) begin
        hcnt <= hs_fall ? 10'd0 : sat_inc(hcnt);
        if (hs_fall)
          h_total_meas <= htot_now;
        if (blank_fall) begin
          h_active_meas <= acnt;
          acnt          <= '0;
        end else if (blank_q) begin
          acnt <= sat_inc(acnt);
        end
        if (blank_rise)
          RecX <= '0;
        else if (blank_q)
          RecX <= sat_inc(RecX);
        // alcnt holds the rises already seen this frame, i.e. the row of this one.
        if (blank_rise)
          RecY <= vs_fall ? 10'd0 : alcnt;
        if (vs_fall) begin
          lcnt      <= '0;
          alcnt     <= blank_rise ? 10'd1 : 10'd0;
          frame_bad <= 1'b0;
        end else begin
          if (hs_fall)
            lcnt <= sat_inc(lcnt);
          if (blank_rise)
            alcnt <= sat_inc(alcnt);
          if (line_bad && state != HUNT)
            frame_bad <= 1'b1;
        end
        line_err <= line_bad & (state != HUNT);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= HUNT;
      locked       <= 1'b0;
      good_cnt     <= '0;
      err_count    <= '0;
      frame_done   <= 1'b0;
      v_total_meas <= '0;
    end else begin
      frame_done <= 1'b0;
      if (watchdog) begin
        state    <= HUNT;
        locked   <= 1'b0;
        good_cnt <= '0;
      end else if (vs_fall) begin
        case (state)
          HUNT: begin
            state    <= MEASURE;
            good_cnt <= '0;
          end
          MEASURE: begin
            frame_done   <= 1'b1;
            v_total_meas <= lcnt_end;
            if (frame_good) begin
              good_cnt <= good_next;
              if (good_next >= LOCK_N) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              good_cnt <= '0;
            end
          end
          LOCKED: begin
            frame_done   <= 1'b1;
            v_total_meas <= lcnt_end;
            if (!frame_good) begin
              state     <= MEASURE;
              locked    <= 1'b0;
              good_cnt  <= '0;
              err_count <= (err_count == 8'hFF) ? err_count : err_count + 8'd1;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_vga_sync_monitor.sv
// Drives a scaled-down VGA raster and compares the monitor against a frame-level reference model.
module tb_vga_sync_monitor;
  localparam int HT    = 20;
  localparam int HA    = 12;
  localparam int VT    = 12;
  localparam int VA    = 6;
  localparam int LOCKN = 2;
  localparam int STALL = 16;
  localparam int HS0   = HA + 2;
  localparam int VS0   = VA + 2;

  logic       Clk = 1'b0;
  logic       Reset, pixel_clk, hs, vs, blank;
  logic       pix_valid, locked, line_err, frame_done;
  logic [9:0] RecX, RecY, h_total_meas, h_active_meas, v_total_meas;
  logic [7:0] err_count;

  vga_sync_monitor #(
    .EXP_HTOTAL(HT), .EXP_HACTIVE(HA), .EXP_VTOTAL(VT), .EXP_VACTIVE(VA),
    .LOCK_FRAMES(LOCKN), .STALL_CYCLES(STALL)
  ) dut (
    .Clk(Clk), .Reset(Reset), .pixel_clk(pixel_clk), .hs(hs), .vs(vs), .blank(blank),
    .pix_valid(pix_valid), .RecX(RecX), .RecY(RecY), .locked(locked),
    .line_err(line_err), .frame_done(frame_done), .h_total_meas(h_total_meas),
    .h_active_meas(h_active_meas), .v_total_meas(v_total_meas), .err_count(err_count)
  );

  always #10 Clk = ~Clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: 0 = hunting, 1 = measuring, 2 = locked.
  int m_state, m_good, m_err, m_vtot, m_htot, m_hact;
  int m_since_hs, m_run, m_lines, m_alines;
  bit m_bad;
  int m_line_errs = 0;
  int m_frames = 0;
  int exp_q[$];
  int got_q[$];
  int got_line_errs = 0;
  int got_frames = 0;

  always @(negedge Clk) begin
    if (!Reset) begin
      if (pix_valid) got_q.push_back(int'(RecX) * 1024 + int'(RecY));
      if (line_err) got_line_errs++;
      if (frame_done) got_frames++;
    end
  end

  task automatic model_reset();
    m_state = 0; m_good = 0; m_err = 0; m_vtot = 0; m_htot = 0; m_hact = 0;
    m_since_hs = 0; m_run = 0; m_lines = 0; m_alines = 0; m_bad = 0;
  endtask

  task automatic line_error();
    if (m_state != 0) begin
      m_line_errs++;
      m_bad = 1;
    end
  endtask

  task automatic frame_end();
    bit good;
    if (m_state == 0) begin
      m_state = 1;
      m_good  = 0;
    end else begin
      m_frames++;
      m_vtot = m_lines;
      good = !m_bad && m_lines == VT && m_alines == VA;
      if (m_state == 1) begin
        if (good) begin
          m_good++;
          if (m_good >= LOCKN) m_state = 2;
        end else begin
          m_good = 0;
        end
      end else if (!good) begin
        m_state = 1;
        m_good  = 0;
        if (m_err < 255) m_err++;
      end
    end
    m_lines = 0; m_alines = 0; m_bad = 0;
  endtask

  task automatic model_pix(input bit hstart, input bit vstart, input bit b, input bit bfall,
                           input bit brise, input int x, input int y);
    m_since_hs++;
    if (hstart) begin
      m_htot = m_since_hs;
      if (m_since_hs != HT) line_error();
      m_since_hs = 0;
      m_lines++;
    end
    if (bfall) begin
      m_hact = m_run;
      if (m_run != HA) line_error();
      m_run = 0;
    end
    if (b) m_run++;
    if (brise) m_alines++;
    if (b && m_state == 2) exp_q.push_back(x * 1024 + y);
    if (vstart) frame_end();
  endtask

  task automatic pix(input logic h, input logic v, input logic b);
    @(negedge Clk);
    hs = h; vs = v; blank = b; pixel_clk = 1'b1;
    @(negedge Clk);
    pixel_clk = 1'b0;
  endtask

  task automatic compare_pix();
    int mism;
    int first_got;
    int last_got;
    mism = 0;
    check("pix_count", longint'(got_q.size()), longint'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i] != exp_q[i]) mism++;
    check("pix_coords", longint'(mism), 0);
    if (exp_q.size() > 0) begin
      first_got = (got_q.size() > 0) ? got_q[0] : -1;
      last_got  = (got_q.size() > 0) ? got_q[got_q.size()-1] : -1;
      check("pix_first", longint'(first_got), longint'(exp_q[0]));
      check("pix_last", longint'(last_got), longint'(exp_q[exp_q.size()-1]));
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic checkpoint();
    check("locked", longint'(locked), longint'(m_state == 2));
    check("err_count", longint'(err_count), longint'(m_err));
    check("v_total_meas", longint'(v_total_meas), longint'(m_vtot));
    check("h_total_meas", longint'(h_total_meas), longint'(m_htot));
    check("h_active_meas", longint'(h_active_meas), longint'(m_hact));
    check("line_err_pulses", longint'(got_line_errs), longint'(m_line_errs));
    check("frame_done_pulses", longint'(got_frames), longint'(m_frames));
    compare_pix();
  endtask

  task automatic all_outputs_zero(input string tag);
    logic [61:0] outs;
    outs = {pix_valid, RecX, RecY, locked, line_err, frame_done,
            h_total_meas, h_active_meas, v_total_meas, err_count};
    check(tag, longint'(outs), 0);
  endtask

  task automatic do_reset();
    repeat (2) @(negedge Clk);
    compare_pix();
    Reset = 1'b1;
    #1;
    all_outputs_zero("reset_midframe_outputs");
    model_reset();
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic do_stall();
    repeat (8) @(negedge Clk);
    check("stall_early_locked", longint'(locked), longint'(m_state == 2));
    repeat (12) @(negedge Clk);
    m_state = 0;
    m_good  = 0;
    check("stall_locked", longint'(locked), longint'(m_state == 2));
    check("stall_err_count", longint'(err_count), longint'(m_err));
  endtask

  task automatic send_frame(input int nlines, input int vx, input int stretch_y,
                            input int short_y, input int reset_y, input bit stall);
    int len, ha_l, pos, vpos;
    bit act, hsl, vsl;
    vpos = VS0 * 64 + vx;
    for (int y = 0; y < nlines; y++) begin
      len  = HT + ((y == stretch_y) ? 1 : 0);
      ha_l = (y == short_y) ? HA - 1 : HA;
      for (int x = 0; x < len; x++) begin
        act = (y < VA) && (x < ha_l);
        hsl = (x >= HS0) && (x < HS0 + 3);
        pos = y * 64 + x;
        vsl = (pos >= vpos) && (pos < vpos + 128);
        if (y == reset_y && x == 3) do_reset();
        pix(!hsl, !vsl, act);
        model_pix(x == HS0, pos == vpos, act, (y < VA) && (x == ha_l),
                  (y < VA) && (x == 0), x, y);
      end
      if (y == VS0) begin
        checkpoint();
        if (stall) do_stall();
      end
    end
  endtask

  initial begin
    int kind, vx;
    Reset = 1'b1; pixel_clk = 1'b0; hs = 1'b1; vs = 1'b1; blank = 1'b0;
    model_reset();
    repeat (3) @(negedge Clk);
    all_outputs_zero("reset_state");
    Reset = 1'b0;

    // Lock with hs and vs falling on the same strobe.
    repeat (4) send_frame(VT, HS0, -1, -1, -1, 1'b0);
    send_frame(VT, HS0, 2, -1, -1, 1'b0);
    repeat (2) send_frame(VT, HS0, -1, -1, -1, 1'b0);
    send_frame(VT - 1, HS0, -1, -1, -1, 1'b0);
    repeat (3) send_frame(VT, HS0, -1, -1, -1, 1'b0);
    send_frame(VT, HS0, -1, -1, -1, 1'b1);
    repeat (4) send_frame(VT, HS0, -1, -1, -1, 1'b0);
    send_frame(VT, HS0, -1, -1, 3, 1'b0);
    repeat (3) send_frame(VT, HS0, -1, -1, -1, 1'b0);

    vx = 0;
    for (int f = 0; f < 24; f++) begin
      kind = $urandom_range(0, 10);
      if ($urandom_range(0, 5) == 0) vx = (vx == 0) ? HS0 : 0;
      case (kind)
        6:       send_frame(VT, vx, $urandom_range(0, VA - 1), -1, -1, 1'b0);
        7:       send_frame(VT, vx, -1, $urandom_range(0, VA - 1), -1, 1'b0);
        8:       send_frame(VT - 1, vx, -1, -1, -1, 1'b0);
        9:       send_frame(VT + 1, vx, -1, -1, -1, 1'b0);
        10:      send_frame(VT, vx, -1, -1, -1, 1'b1);
        default: send_frame(VT, vx, -1, -1, -1, 1'b0);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
